// File: rtl/tag_sort_pkg.sv
// Shared definitions for the tag-sort multibit-tree pipeline.
// Tag width and the "no match" encoding are common to every tree stage and the drain.
package tag_sort_pkg;

    localparam int TAG_W = 12;

    // All-ones tag means the tree found no matching entry.
    localparam logic [TAG_W-1:0] NO_MATCH_TAG = {TAG_W{1'b1}};

    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_CNT_W = 16;

    // One result as it leaves the last stage register.
    typedef struct packed {
        logic [TAG_W-1:0] matching;
        logic [TAG_W-1:0] incoming;
    } tag_pair_t;

    // A result is a hit when the matching tag carries a real entry.
    function automatic logic tag_is_hit(input logic [TAG_W-1:0] tag);
        return (tag != NO_MATCH_TAG);
    endfunction

endpackage

// File: rtl/tag_sort_sync_fifo.sv
// Small synchronous FIFO holding tag pairs for the result drain.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter;
// full, empty and level are all registered from the next-state pointers.
module tag_sort_sync_fifo
    import tag_sort_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  tag_pair_t              wr_data,
    output tag_pair_t              rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_d;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] rd_ptr_d;
    logic          full_q;
    logic          full_d;
    logic          empty_q;
    logic          empty_d;
    logic [PW-1:0] level_q;
    logic [PW-1:0] level_d;
    tag_pair_t     mem_q [DEPTH];
    tag_pair_t     mem_d [DEPTH];

    logic push_ok_s;
    logic pop_ok_s;

    // Qualify requests: never write when full, never read when empty, flush wins over both.
    always_comb begin
        push_ok_s = push && !full_q && !flush;
        pop_ok_s  = pop && !empty_q && !flush;
    end

    // Next pointer values; flush brings both pointers back together at zero.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // Status flags derived from the next pointers so they are ready right after the edge.
    always_comb begin
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        level_d = wr_ptr_d - rd_ptr_d;
    end

    // Storage update: only the slot under the write pointer changes on a push.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push_ok_s) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_data;
        end else begin
            mem_d[wr_ptr_q[AW-1:0]] = mem_q[wr_ptr_q[AW-1:0]];
        end
    end

    // State registers; entries reset to zero so the head is never unknown.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            level_q  <= {PW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            level_q  <= level_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Head entry and registered status straight out.
    always_comb begin
        rd_data = mem_q[rd_ptr_q[AW-1:0]];
        full    = full_q;
        empty   = empty_q;
        level   = level_q;
    end

endmodule

// File: rtl/tag_sort_result_drain.sv
// Sink end of the tag-sort tree pipeline.
// Buffers {matching, incoming} results, stalls the pipeline through pipe_ena when the
// buffer is full, presents results on valid/ready and keeps accept/hit statistics.
// pipe_ena depends only on the registered full flag, never on out_ready.
module tag_sort_result_drain
    import tag_sort_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [TAG_W-1:0]       matching_tag_in,
    input  logic [TAG_W-1:0]       incoming_tag_in,
    output logic                   pipe_ena,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TAG_W-1:0]       out_matching_tag,
    output logic [TAG_W-1:0]       out_incoming_tag,
    output logic                   out_hit,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_W-1:0]       accept_cnt,
    output logic [CNT_W-1:0]       hit_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic                   full_s;
    logic                   empty_s;
    logic                   push_s;
    logic                   pop_s;
    logic [$clog2(DEPTH):0] level_s;
    tag_pair_t              wr_pair_s;
    tag_pair_t              head_s;

    logic [CNT_W-1:0] accept_cnt_q;
    logic [CNT_W-1:0] accept_cnt_d;
    logic [CNT_W-1:0] hit_cnt_q;
    logic [CNT_W-1:0] hit_cnt_d;

    // Handshake: a result is taken only while the stages are enabled and no flush is active.
    always_comb begin
        push_s              = in_valid && !full_s && !flush;
        pop_s               = !empty_s && out_ready && !flush;
        wr_pair_s.matching  = matching_tag_in;
        wr_pair_s.incoming  = incoming_tag_in;
    end

    tag_sort_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_s),
        .pop     (pop_s),
        .flush   (flush),
        .wr_data (wr_pair_s),
        .rd_data (head_s),
        .full    (full_s),
        .empty   (empty_s),
        .level   (level_s)
    );

    // Statistics: count every accepted result and those that carried a real match.
    always_comb begin
        accept_cnt_d = accept_cnt_q;
        hit_cnt_d    = hit_cnt_q;
        if (push_s) begin
            accept_cnt_d = accept_cnt_q + CNT_ONE;
            if (tag_is_hit(matching_tag_in)) begin
                hit_cnt_d = hit_cnt_q + CNT_ONE;
            end else begin
                hit_cnt_d = hit_cnt_q;
            end
        end else begin
            accept_cnt_d = accept_cnt_q;
            hit_cnt_d    = hit_cnt_q;
        end
    end

    // Counter registers; flush leaves them alone, only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            accept_cnt_q <= {CNT_W{1'b0}};
            hit_cnt_q    <= {CNT_W{1'b0}};
        end else begin
            accept_cnt_q <= accept_cnt_d;
            hit_cnt_q    <= hit_cnt_d;
        end
    end

    // Output drive: head entry, hit decode and the stall enable.
    always_comb begin
        pipe_ena         = !full_s;
        out_valid        = !empty_s;
        out_matching_tag = head_s.matching;
        out_incoming_tag = head_s.incoming;
        out_hit          = tag_is_hit(head_s.matching);
        level            = level_s;
        accept_cnt       = accept_cnt_q;
        hit_cnt          = hit_cnt_q;
    end

endmodule
